// File: rtl/pfpu_wb_pkg.sv
// Shared definitions for the PFPU writeback stage: unit codes, slot record, latencies.
package pfpu_wb_pkg;

  localparam int unsigned LAT_FADD = 5;
  localparam int unsigned LAT_FMUL = 6;
  localparam int unsigned LAT_MISC = 1;
  localparam int unsigned MAXLAT   = 6;
  localparam int unsigned REGW     = 7;
  localparam int unsigned SLOTW    = $clog2(MAXLAT + 1);

  typedef enum logic [1:0] {
    UNIT_MISC = 2'd0,
    UNIT_FADD = 2'd1,
    UNIT_FMUL = 2'd2,
    UNIT_NONE = 2'd3
  } unit_t;

  typedef struct packed {
    logic            v;
    unit_t           unit;
    logic [REGW-1:0] dst;
  } slot_t;

  function automatic logic [SLOTW-1:0] lat_of(input unit_t u);
    case (u)
      UNIT_MISC: return SLOTW'(LAT_MISC);
      UNIT_FADD: return SLOTW'(LAT_FADD);
      UNIT_FMUL: return SLOTW'(LAT_FMUL);
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/pfpu_wb_if.sv
// Issue, unit-result and register-file write bundle of the PFPU writeback stage.
interface pfpu_wb_if;
  import pfpu_wb_pkg::*;

  logic            issue_valid;
  logic [1:0]      issue_unit;
  logic [REGW-1:0] issue_dst;
  logic            issue_ready;
  logic [31:0]     misc_r;
  logic            misc_valid;
  logic [31:0]     fadd_r;
  logic            fadd_valid;
  logic [31:0]     fmul_r;
  logic            fmul_valid;
  logic            regf_we;
  logic [REGW-1:0] regf_waddr;
  logic [31:0]     regf_wdat;
  logic            busy;
  logic            err_missing;
  logic            err_unexpected;
  logic [15:0]     wb_count;

  modport master (
    output issue_valid, issue_unit, issue_dst,
    output misc_r, misc_valid, fadd_r, fadd_valid, fmul_r, fmul_valid,
    input  issue_ready, regf_we, regf_waddr, regf_wdat,
    input  busy, err_missing, err_unexpected, wb_count
  );

  modport slave (
    input  issue_valid, issue_unit, issue_dst,
    input  misc_r, misc_valid, fadd_r, fadd_valid, fmul_r, fmul_valid,
    output issue_ready, regf_we, regf_waddr, regf_wdat,
    output busy, err_missing, err_unexpected, wb_count
  );

endinterface

// File: rtl/pfpu_wb_slotline.sv
// Latency-indexed slot line: shifts toward slot[0] each cycle and reserves the
// completion cycle of every accepted op so no two results can collide.
module pfpu_wb_slotline
  import pfpu_wb_pkg::*;
(
  input  logic            sys_clk,
  input  logic            alu_rst,
  input  logic            issue_fire,
  input  unit_t           issue_unit,
  input  logic [REGW-1:0] issue_dst,
  output slot_t           head,
  output logic [3:0]      unit_ready,
  output logic            any_valid
);

  slot_t            slot [MAXLAT];
  logic [MAXLAT:0]  ahead;
  logic [SLOTW-1:0] tgt;

  // ahead[MAXLAT] is always clear, so the longest-latency unit is never blocked.
  always_comb begin
    ahead = '0;
    for (int unsigned i = 0; i < MAXLAT; i++) begin
      ahead[i] = slot[i].v;
    end
  end

  // A unit with latency L is blocked when slot[L] is valid: it would shift into slot[L-1].
  always_comb begin
    unit_ready            = '0;
    unit_ready[UNIT_MISC] = ~ahead[lat_of(UNIT_MISC)];
    unit_ready[UNIT_FADD] = ~ahead[lat_of(UNIT_FADD)];
    unit_ready[UNIT_FMUL] = ~ahead[lat_of(UNIT_FMUL)];
    unit_ready[UNIT_NONE] = 1'b1;
  end

  assign tgt       = lat_of(issue_unit) - SLOTW'(1);
  assign head      = slot[0];
  assign any_valid = |ahead;

  always_ff @(posedge sys_clk) begin
    if (alu_rst) begin
      for (int unsigned i = 0; i < MAXLAT; i++) begin
        slot[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MAXLAT - 1; i++) begin
        slot[i] <= slot[i+1];
      end
      slot[MAXLAT-1] <= '0;
      if (issue_fire) begin
        slot[tgt] <= '{v: 1'b1, unit: issue_unit, dst: issue_dst};
      end
    end
  end

endmodule

// File: rtl/pfpu_wb.sv
// PFPU writeback stage: selects the completing unit's result per the slot line
// and registers it onto the register-file write port; tracks errors and count.
module pfpu_wb
  import pfpu_wb_pkg::*;
(
  input logic        sys_clk,
  input logic        alu_rst,
  pfpu_wb_if.slave   bus
);

  unit_t           iu;
  slot_t           head;
  logic [3:0]      unit_ready;
  logic            any_valid;
  logic            issue_fire;
  logic            sel_valid;
  logic [31:0]     sel_data;
  logic            missing;
  logic            unexpected;
  logic            regf_we_q;
  logic [REGW-1:0] regf_waddr_q;
  logic [31:0]     regf_wdat_q;
  logic            err_missing_q;
  logic            err_unexpected_q;
  logic [15:0]     wb_count_q;

  assign iu              = unit_t'(bus.issue_unit);
  assign bus.issue_ready = unit_ready[iu];
  assign issue_fire      = bus.issue_valid && unit_ready[iu] && (iu != UNIT_NONE);

  pfpu_wb_slotline u_slotline (
    .sys_clk    (sys_clk),
    .alu_rst    (alu_rst),
    .issue_fire (issue_fire),
    .issue_unit (iu),
    .issue_dst  (bus.issue_dst),
    .head       (head),
    .unit_ready (unit_ready),
    .any_valid  (any_valid)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    case (head.unit)
      UNIT_MISC: begin sel_valid = bus.misc_valid; sel_data = bus.misc_r; end
      UNIT_FADD: begin sel_valid = bus.fadd_valid; sel_data = bus.fadd_r; end
      UNIT_FMUL: begin sel_valid = bus.fmul_valid; sel_data = bus.fmul_r; end
      default:   begin sel_valid = 1'b0;           sel_data = '0;         end
    endcase
    missing    = head.v && !sel_valid;
    unexpected = (bus.misc_valid && !(head.v && head.unit == UNIT_MISC))
               | (bus.fadd_valid && !(head.v && head.unit == UNIT_FADD))
               | (bus.fmul_valid && !(head.v && head.unit == UNIT_FMUL));
  end

  always_ff @(posedge sys_clk) begin
    if (alu_rst) begin
      regf_we_q        <= 1'b0;
      regf_waddr_q     <= '0;
      regf_wdat_q      <= '0;
      err_missing_q    <= 1'b0;
      err_unexpected_q <= 1'b0;
      wb_count_q       <= '0;
    end else begin
      regf_we_q <= head.v;
      if (head.v) begin
        regf_waddr_q <= head.dst;
        regf_wdat_q  <= sel_data;
      end
      if (missing)    err_missing_q    <= 1'b1;
      if (unexpected) err_unexpected_q <= 1'b1;
      wb_count_q <= wb_count_q + 16'(regf_we_q);
    end
  end

  assign bus.regf_we        = regf_we_q;
  assign bus.regf_waddr     = regf_waddr_q;
  assign bus.regf_wdat      = regf_wdat_q;
  assign bus.busy           = any_valid | regf_we_q;
  assign bus.err_missing    = err_missing_q;
  assign bus.err_unexpected = err_unexpected_q;
  assign bus.wb_count       = wb_count_q;

endmodule

// File: tb/tb_pfpu_wb.sv
// Directed bench for pfpu_wb: expected writebacks are queued at issue and
// matched (cycle, address, data) as the register-file port fires.
module tb_pfpu_wb;

  typedef struct {
    int          cyc;
    logic [6:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  logic    sys_clk = 1'b0;
  logic    alu_rst = 1'b1;
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  wb_exp_t exp_q[$];
  wb_exp_t e;

  pfpu_wb_if bus ();

  pfpu_wb dut (
    .sys_clk (sys_clk),
    .alu_rst (alu_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    int guard = 0;
    while (cyc < c && guard < 1000) begin
      step();
      guard++;
    end
    check("wait_bound", 32'(cyc), 32'(c));
  endtask

  task automatic clear_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_unit  = 2'd3;
    bus.issue_dst   = '0;
    bus.misc_valid  = 1'b0;
    bus.misc_r      = '0;
    bus.fadd_valid  = 1'b0;
    bus.fadd_r      = '0;
    bus.fmul_valid  = 1'b0;
    bus.fmul_r      = '0;
  endtask

  task automatic issue(input logic [1:0] unit, input logic [6:0] dst);
    bus.issue_valid = 1'b1;
    bus.issue_unit  = unit;
    bus.issue_dst   = dst;
    #1;
  endtask

  // Scoreboard consumer: every write must match the oldest expectation exactly.
  always @(negedge sys_clk) begin
    if (bus.regf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_spurious", 32'(bus.regf_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_cycle", 32'(cyc), 32'(e.cyc));
        check("wb_addr", 32'(bus.regf_waddr), 32'(e.addr));
        check("wb_data", bus.regf_wdat, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    clear_inputs();
    alu_rst = 1'b1;
    step(); step(); step();
    alu_rst = 1'b0;

    check("rst_we", 32'(bus.regf_we), 32'd0);
    check("rst_waddr", 32'(bus.regf_waddr), 32'd0);
    check("rst_wdat", bus.regf_wdat, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err_missing", 32'(bus.err_missing), 32'd0);
    check("rst_err_unexp", 32'(bus.err_unexpected), 32'd0);
    check("rst_wb_count", 32'(bus.wb_count), 32'd0);

    // Single fmul
    t0 = cyc;
    issue(2'd2, 7'h12);
    check("t1_ready", 32'(bus.issue_ready), 32'd1);
    exp_q.push_back('{t0 + 7, 7'h12, 32'h3F80_0000});
    step();
    clear_inputs();
    wait_until(t0 + 3);
    check("t1_busy_flight", 32'(bus.busy), 32'd1);
    wait_until(t0 + 6);
    bus.fmul_valid = 1'b1;
    bus.fmul_r     = 32'h3F80_0000;
    step();
    clear_inputs();
    check("t1_busy_wb", 32'(bus.busy), 32'd1);
    step();
    check("t1_wb_count", 32'(bus.wb_count), 32'd1);
    check("t1_busy_idle", 32'(bus.busy), 32'd0);

    // fmul then fadd one cycle later collides and is held off a cycle
    t0 = cyc;
    issue(2'd2, 7'h20);
    exp_q.push_back('{t0 + 7, 7'h20, 32'h4000_0000});
    step();
    clear_inputs();
    issue(2'd1, 7'h21);
    check("t2_blocked", 32'(bus.issue_ready), 32'd0);
    step();
    check("t2_ready", 32'(bus.issue_ready), 32'd1);
    exp_q.push_back('{t0 + 8, 7'h21, 32'h4040_0000});
    step();
    clear_inputs();
    wait_until(t0 + 6);
    bus.fmul_valid = 1'b1;
    bus.fmul_r     = 32'h4000_0000;
    step();
    clear_inputs();
    bus.fadd_valid = 1'b1;
    bus.fadd_r     = 32'h4040_0000;
    step();
    clear_inputs();
    wait_until(t0 + 10);
    check("t2_wb_count", 32'(bus.wb_count), 32'd3);
    check("t2_err_missing", 32'(bus.err_missing), 32'd0);
    check("t2_err_unexp", 32'(bus.err_unexpected), 32'd0);

    // misc every cycle, results one cycle later
    t0 = cyc;
    for (int i = 0; i <= 10; i++) begin
      clear_inputs();
      if (i > 0) begin
        bus.misc_valid = 1'b1;
        bus.misc_r     = 32'hA000_0000 | 32'(i - 1);
      end
      if (i < 10) begin
        issue(2'd0, 7'(i));
        check("t3_ready", 32'(bus.issue_ready), 32'd1);
        exp_q.push_back('{t0 + i + 2, 7'(i), 32'hA000_0000 | 32'(i)});
      end
      step();
    end
    clear_inputs();
    check("t3_busy_last", 32'(bus.busy), 32'd1);
    step();
    check("t3_busy_fall", 32'(bus.busy), 32'd0);
    check("t3_wb_count", 32'(bus.wb_count), 32'd13);

    // Stray fadd result with nothing in flight
    check("t4_pre_unexp", 32'(bus.err_unexpected), 32'd0);
    bus.fadd_valid = 1'b1;
    bus.fadd_r     = 32'hDEAD_BEEF;
    step();
    clear_inputs();
    check("t4_unexp", 32'(bus.err_unexpected), 32'd1);
    check("t4_no_we", 32'(bus.regf_we), 32'd0);
    step(); step(); step();
    check("t4_unexp_sticky", 32'(bus.err_unexpected), 32'd1);
    check("t4_missing_clear", 32'(bus.err_missing), 32'd0);

    // fadd whose result never shows up still writes what the unit presents
    t0 = cyc;
    issue(2'd1, 7'h05);
    exp_q.push_back('{t0 + 6, 7'h05, 32'h1234_5678});
    step();
    clear_inputs();
    wait_until(t0 + 5);
    check("t5_pre_missing", 32'(bus.err_missing), 32'd0);
    bus.fadd_r = 32'h1234_5678;
    step();
    clear_inputs();
    check("t5_missing", 32'(bus.err_missing), 32'd1);
    step();
    check("t5_wb_count", 32'(bus.wb_count), 32'd14);

    // Reset mid-flight discards everything silently
    t0 = cyc;
    issue(2'd1, 7'h30);
    step();
    clear_inputs();
    issue(2'd2, 7'h31);
    check("t6_fmul_ready", 32'(bus.issue_ready), 32'd1);
    step();
    clear_inputs();
    step();
    check("t6_busy_pre", 32'(bus.busy), 32'd1);
    alu_rst = 1'b1;
    step();
    alu_rst = 1'b0;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_we", 32'(bus.regf_we), 32'd0);
    check("t6_err_missing", 32'(bus.err_missing), 32'd0);
    check("t6_err_unexp", 32'(bus.err_unexpected), 32'd0);
    check("t6_wb_count", 32'(bus.wb_count), 32'd0);
    wait_until(t0 + 12);
    check("t6_busy_late", 32'(bus.busy), 32'd0);
    check("t6_err_missing_late", 32'(bus.err_missing), 32'd0);
    check("t6_wb_count_late", 32'(bus.wb_count), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
